// File: rtl/clock_seq_pkg.sv
// Shared types and defaults for the clocking-wizard bring-up sequencer.
package clock_seq_pkg;

  // Sequencer states; the numeric encoding is what o_state reports.
  typedef enum logic [2:0] {
    PULSE     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    REL_SYS   = 3'd3,
    RUN       = 3'd4,
    FAIL      = 3'd5
  } seq_state_e;

  localparam int DEF_RESET_PULSE_CYCLES  = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int DEF_STAGGER_CYCLES      = 64;
  localparam int DEF_MAX_RETRIES         = 3;

  // Largest of three values; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer for a single level signal crossing into clk_i.
module sync_2ff (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Capture the asynchronous input and give the first stage a cycle to settle.
  // NOTE: the synchronizer chain carries no reset; a reset term would add logic
  // in the metastability path and the chain flushes itself within two cycles.
  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clock_reset_sequencer.sv
// Brings up the clocking wizard: pulses its reset, waits for a stable lock
// (with timeout and bounded retries), then releases the system-domain and
// ADC-domain resets in a fixed, staggered order.
module clock_reset_sequencer
  import clock_seq_pkg::*;
#(
  parameter int RESET_PULSE_CYCLES  = DEF_RESET_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_locked,
  input  logic                             i_restart,
  output logic                             o_mmcm_reset,
  output logic                             o_sys_reset,
  output logic                             o_adc_reset,
  output logic                             o_valid,
  output logic                             o_error,
  output logic [$clog2(MAX_RETRIES+1)-1:0] o_retry_count,
  output logic [2:0]                       o_state
);

  // One down-counter serves the pulse, stable and stagger phases; it is
  // loaded with (length - 1) on phase entry and the phase ends when it hits 0.
  localparam int CNT_MAX = max3(RESET_PULSE_CYCLES - 1, LOCK_STABLE_CYCLES - 1,
                                STAGGER_CYCLES - 1);
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(RESET_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT    = TMO_W'(LOCK_TIMEOUT_CYCLES);
  localparam logic [RTY_W-1:0] RTY_MAX      = RTY_W'(MAX_RETRIES);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMO_W-1:0] tmo_inc;
  logic             timeout_hit;
  logic             lock_s;

  sync_2ff u_lock_sync (
    .clk_i (i_clock),
    .d_i   (i_locked),
    .q_o   (lock_s)
  );

  // State, phase counter, timeout counter and retry count; reset parks the
  // sequencer at the start of a full-length wizard reset pulse.
  // NOTE: all state updates use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= PULSE;
      cnt_q   <= PULSE_LOAD;
      tmo_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic: restart beats timeout, timeout beats lock loss.
  // NOTE: every variable gets a hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    tmo_inc     = tmo_q + 1'b1;
    timeout_hit = (tmo_inc == TMO_LIMIT);

    if (i_restart) begin
      state_d = PULSE;
      cnt_d   = PULSE_LOAD;
      tmo_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        PULSE: begin
          tmo_d = '0;
          if (cnt_q == '0) begin
            state_d = WAIT_LOCK;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        WAIT_LOCK, STABLE: begin
          tmo_d = tmo_inc;
          if (timeout_hit) begin
            if (retry_q == RTY_MAX) begin
              state_d = FAIL;
            end else begin
              state_d = PULSE;
              cnt_d   = PULSE_LOAD;
              tmo_d   = '0;
              retry_d = retry_q + 1'b1;
            end
          end else if (state_q == WAIT_LOCK) begin
            if (lock_s) begin
              state_d = STABLE;
              cnt_d   = STABLE_LOAD;
            end
          end else if (!lock_s) begin
            // A dropout restarts the stable window; the timeout keeps running.
            state_d = WAIT_LOCK;
            cnt_d   = STABLE_LOAD;
          end else if (cnt_q == '0) begin
            state_d = REL_SYS;
            cnt_d   = STAGGER_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        REL_SYS: begin
          if (!lock_s) begin
            state_d = PULSE;
            cnt_d   = PULSE_LOAD;
            tmo_d   = '0;
            retry_d = '0;
          end else if (cnt_q == '0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        RUN: begin
          // Losing lock after a good bring-up starts afresh, not as a retry.
          if (!lock_s) begin
            state_d = PULSE;
            cnt_d   = PULSE_LOAD;
            tmo_d   = '0;
            retry_d = '0;
          end
        end

        FAIL: begin
          state_d = FAIL;
        end

        default: begin
          state_d = PULSE;
          cnt_d   = PULSE_LOAD;
          tmo_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the registered state only; no input reaches an output.
  always_comb begin
    o_mmcm_reset = 1'b1;
    o_sys_reset  = 1'b1;
    o_adc_reset  = 1'b1;
    o_valid      = 1'b0;
    o_error      = 1'b0;
    case (state_q)
      WAIT_LOCK, STABLE: begin
        o_mmcm_reset = 1'b0;
      end
      REL_SYS: begin
        o_mmcm_reset = 1'b0;
        o_sys_reset  = 1'b0;
      end
      RUN: begin
        o_mmcm_reset = 1'b0;
        o_sys_reset  = 1'b0;
        o_adc_reset  = 1'b0;
        o_valid      = 1'b1;
      end
      FAIL: begin
        o_error = 1'b1;
      end
      default: begin
        o_mmcm_reset = 1'b1;
      end
    endcase
  end

  assign o_retry_count = retry_q;
  assign o_state       = state_q;

endmodule

// File: doc/clock_reset_sequencer.md
# clock_reset_sequencer

Sequences bring-up of the clocking wizard that derives the 100 MHz system clock and 400 MHz ADC clock from the 125 MHz board clock.
- Runs on the free-running board clock and pulses the wizard reset.
- Waits for a stable lock, with timeout and bounded retries.
- Releases the system-domain and ADC-domain resets in a fixed, staggered order, then reports clocks-valid.
- Downstream reset synchronizers in the 100/400 MHz domains consume `o_sys_reset`/`o_adc_reset`.

## Interface

Parameters:
- `RESET_PULSE_CYCLES`, 16: wizard reset pulse width, in `i_clock` cycles.
- `LOCK_TIMEOUT_CYCLES`, 65536: maximum cycles from wizard reset release to start of reset release, about 0.5 ms.
- `LOCK_STABLE_CYCLES`, 1024: consecutive cycles of synchronized lock required.
- `STAGGER_CYCLES`, 64: delay from `o_sys_reset` release to `o_adc_reset` release.
- `MAX_RETRIES`, 3: timeouts tolerated before the block declares failure.

Ports:
- `i_clock` in 1: 125 MHz free-running board clock; the only clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_locked` in 1: wizard lock, asynchronous to `i_clock`.
- `i_restart` in 1: single-cycle re-initialisation request.
- `o_mmcm_reset` out 1: wizard reset, active-high.
- `o_sys_reset` out 1: system-domain reset request, active-high.
- `o_adc_reset` out 1: ADC-domain reset request, active-high.
- `o_valid` out 1: high when both clocks are usable.
- `o_error` out 1: sticky lock failure.
- `o_retry_count` out `$clog2(MAX_RETRIES+1)`: number of timeouts in the current bring-up.
- `o_state` out 3: current FSM state, for debug.

## Operation

- `i_locked` passes through a 2-FF synchronizer; its output is `lock_s`.
- FSM states and transitions:
  - **PULSE:** `o_mmcm_reset`=1 for `RESET_PULSE_CYCLES`, then go to WAIT_LOCK. The timeout counter clears on entry.
  - **WAIT_LOCK:** on `lock_s`=1, go to STABLE.
  - **STABLE:** counts consecutive `lock_s`=1 cycles. If `lock_s`=0, return to WAIT_LOCK with the stable count cleared; the timeout counter keeps running. After `LOCK_STABLE_CYCLES`, go to REL_SYS.
  - **REL_SYS:** `o_sys_reset`=0; after `STAGGER_CYCLES`, go to RUN.
  - **RUN:** `o_adc_reset`=0 and `o_valid`=1.
  - **FAIL:** `o_error`=1. `o_mmcm_reset`, `o_sys_reset` and `o_adc_reset` are all held at 1.
- **Timeout:** the timeout counter runs in WAIT_LOCK and STABLE. When it reaches `LOCK_TIMEOUT_CYCLES`:
  - if `retry == MAX_RETRIES`, go to FAIL;
  - otherwise increment `retry` and go to PULSE.
- **Lock loss:** `lock_s`=0 in REL_SYS or RUN goes to PULSE and clears `retry`. A lock loss after a successful bring-up is not a retry.
- **`i_restart`:** from any state, go to PULSE and clear `retry` and `o_error`.
- **Event priority:** `i_reset` > `i_restart` > timeout > lock loss.
- `o_retry_count` saturates at `MAX_RETRIES` and never wraps.

## Timing

- All outputs are registered directly from the state and counters; none is combinational from an input.
- Reset values:
  - state = PULSE;
  - `o_mmcm_reset`, `o_sys_reset`, `o_adc_reset` = 1;
  - `o_valid`, `o_error` = 0;
  - `o_retry_count` = 0.
- Let edge k be the first edge that samples `i_reset`=0:
  - `o_mmcm_reset` falls after edge k+`RESET_PULSE_CYCLES`−1, so it is high for exactly `RESET_PULSE_CYCLES` cycles after reset.
- Lock path latency:
  - `i_locked` reaches `lock_s` 2 cycles later;
  - `o_sys_reset` falls `LOCK_STABLE_CYCLES`+1 edges after `lock_s` first rises, absent any dropout.
- `o_adc_reset` falls and `o_valid` rises on the same edge, exactly `STAGGER_CYCLES` edges after `o_sys_reset` falls.
- On lock loss in RUN: 1 edge after `lock_s`=0, all of the following change together:
  - `o_valid`=0;
  - `o_sys_reset`=1 and `o_adc_reset`=1;
  - `o_mmcm_reset`=1.
- `o_mmcm_reset` is never low while `o_sys_reset` or `o_adc_reset` is being released before lock.
- The two domain resets never release out of order.
- `i_restart` or `i_reset` asserted mid-sequence re-asserts every reset on the next edge; no partially released state persists.

## Structure

- Package `clock_seq_pkg` holds:
  - the state enum, encoded PULSE=0, WAIT_LOCK=1, STABLE=2, REL_SYS=3, RUN=4, FAIL=5 (this encoding is what `o_state` reports);
  - default parameter constants.
- One sub-module, `sync_2ff`: a 1-bit two-stage synchronizer with no reset on the data path.
- The top level holds:
  - one shared down-counter, reused for the pulse, stable and stagger phases;
  - a separate timeout counter sized `$clog2(LOCK_TIMEOUT_CYCLES+1)`;
  - the retry register.

## Test plan

- **Nominal bring-up:** reset, then `i_locked` rises 500 cycles after `o_mmcm_reset` falls.
  - `o_mmcm_reset` is high for 16 cycles.
  - `o_sys_reset` falls at lock+2+1025 cycles.
  - `o_adc_reset` falls and `o_valid` rises 64 cycles later.
- **Lock glitch during STABLE:** `i_locked` low for 3 cycles at stable count 800.
  - The stable count restarts.
  - `o_sys_reset` is delayed by a full 1024 cycles after the glitch; `retry` stays 0.
- **Timeout with retries:** `i_locked` held 0.
  - Wizard reset pulses 4 times in total; `o_retry_count` steps 0→1→2→3.
  - FAIL is entered on the 4th timeout.
  - `o_error`=1 and `o_mmcm_reset` is held at 1.
- **Restart from FAIL:** a 1-cycle `i_restart` pulse.
  - Next edge: PULSE, `o_error`=0, retry 0.
  - Then `i_locked`=1 completes a nominal bring-up.
- **Lock loss in RUN:** `i_locked` drops.
  - 3 edges later: `o_valid`=0, all resets asserted, `o_retry_count`=0, and a new 16-cycle pulse starts.
- **Priority:** `i_restart` and a timeout in the same cycle resolve to restart with retry 0. `i_reset` and `i_restart` in the same cycle produce exactly the reset values.
